mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_map_pkg.sv | 39 +++
 rtl/mmio_out_fifo.sv | 76 +++++++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Memory map shared by the responder and its FIFO: MMIO addresses, STAT layout
// and the address decoder.
package mem_map_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFF00;
    localparam logic [15:0] ADDR_OUT  = 16'hFF00;
    localparam logic [15:0] ADDR_SW   = 16'hFF01;
    localparam logic [15:0] ADDR_CYC  = 16'hFF02;
    localparam logic [15:0] ADDR_STAT = 16'hFF03;

    localparam int STAT_OVF_BIT   = 15;
    localparam int STAT_FULL_BIT  = 5;
    localparam int STAT_EMPTY_BIT = 4;
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 4;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_OUT,
        SEL_SW,
        SEL_CYC,
        SEL_STAT,
        SEL_NONE
    } sel_t;

    function automatic sel_t decode_addr(input logic [15:0] addr);
        if (addr < MMIO_BASE) begin
            return SEL_RAM;
        end
        case (addr)
            ADDR_OUT:  return SEL_OUT;
            ADDR_SW:   return SEL_SW;
            ADDR_CYC:  return SEL_CYC;
            ADDR_STAT: return SEL_STAT;
            default:   return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_out_fifo.sv
// Output FIFO behind the OUT register, with a sticky overflow flag for words
// dropped while full.
module mmio_out_fifo
    import mem_map_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic             ovf_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign count     = count_reg;
    assign overflow  = ovf_reg;
    assign head_data = empty ? '0 : mem_reg[head_reg];

    // When full, a push is only accepted if the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (do_push && (tail_reg == PW'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            if (do_pop) begin
                head_reg <= head_reg + PW'(1);
            end
            if (do_push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (clear_overflow) begin
                ovf_reg <= 1'b0;
            end else if (push && full && !do_pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: wrapping RAM below 0xFF00, MMIO registers
// above it (OUT FIFO, synchronised switches, cycle counter, status).
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic [WIDTH-1:0] memAddr,
    input  logic [WIDTH-1:0] memWriteData,
    output logic [WIDTH-1:0] memReadData,
    input  logic [WIDTH-1:0] switchesIn,
    output logic [WIDTH-1:0] ioData,
    output logic             ioValid,
    input  logic             ioReady
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sel_t             sel;
    logic [AW-1:0]    ram_idx;
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] cyc_reg;
    logic [WIDTH-1:0] stat_word;
    logic [WIDTH-1:0] mmio_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             fifo_ovf;

    assign sel     = decode_addr(16'(memAddr));
    assign ram_idx = memAddr[AW-1:0];
    assign ioValid = !fifo_empty;

    mmio_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (memWrite && (sel == SEL_OUT)),
        .push_data      (memWriteData),
        .pop            (ioValid && ioReady),
        .clear_overflow (memWrite && (sel == SEL_STAT)),
        .head_data      (ioData),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .count          (fifo_count),
        .overflow       (fifo_ovf)
    );

    always_comb begin
        stat_word                                  = '0;
        stat_word[STAT_OVF_BIT]                    = fifo_ovf;
        stat_word[STAT_FULL_BIT]                   = fifo_full;
        stat_word[STAT_EMPTY_BIT]                  = fifo_empty;
        stat_word[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        mmio_rd = '0;
        case (sel)
            SEL_SW:   mmio_rd = sync2_reg;
            SEL_CYC:  mmio_rd = cyc_reg;
            SEL_STAT: mmio_rd = stat_word;
            default:  mmio_rd = '0;
        endcase
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (memWrite && (sel == SEL_RAM)) begin
            ram[ram_idx] <= memWriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memReadData <= '0;
        end else if (memRead && !memWrite) begin
            memReadData <= (sel == SEL_RAM) ? ram[ram_idx] : mmio_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            cyc_reg   <= '0;
        end else begin
            sync1_reg <= switchesIn;
            sync2_reg <= sync1_reg;
            cyc_reg   <= cyc_reg + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, corner-case sequences and a
// randomized run against a queue/array reference model.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int FD    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        ioReady = 1'b0;
    logic [15:0] memAddr = '0;
    logic [15:0] memWriteData = '0;
    logic [15:0] switchesIn = '0;
    logic [15:0] memReadData;
    logic [15:0] ioData;
    logic        ioValid;

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(16), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .reset        (reset),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .switchesIn   (switchesIn),
        .ioData       (ioData),
        .ioValid      (ioValid),
        .ioReady      (ioReady)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] ram_m [DEPTH];
    bit          ram_known [DEPTH];
    logic [15:0] q_m [$];
    bit          ovf_m;
    logic [15:0] cyc_m;
    logic [15:0] sw_d1;
    logic [15:0] sw_d2;
    logic [15:0] exp_rd;
    bit          rd_known;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          ready;
        logic [15:0] exp_rd;
        bit          exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [29];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a, output bit known);
        known = 1'b1;
        if (a < 16'hFF00) begin
            known = ram_known[a % DEPTH];
            return ram_m[a % DEPTH];
        end
        case (a)
            16'hFF01: return sw_d2;
            16'hFF02: return cyc_m;
            16'hFF03: return {ovf_m, 9'b0, q_m.size() == FD, q_m.size() == 0, 4'(q_m.size())};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_edge(input bit rd, input bit wr, input logic [15:0] a,
                              input logic [15:0] wd, input bit rdy);
        logic [15:0] v;
        bit          k;
        bit          was_full;
        bit          pop;
        v = model_read(a, k);
        if (rd && !wr) begin
            exp_rd   = v;
            rd_known = k;
        end
        was_full = (q_m.size() == FD);
        pop = (q_m.size() > 0) && rdy;
        if (pop) void'(q_m.pop_front());
        if (wr && a == 16'hFF00) begin
            if (was_full && !pop) ovf_m = 1'b1;
            else q_m.push_back(wd);
        end
        if (wr && a == 16'hFF03) ovf_m = 1'b0;
        if (wr && a < 16'hFF00) begin
            ram_m[a % DEPTH]     = wd;
            ram_known[a % DEPTH] = 1'b1;
        end
        cyc_m = cyc_m + 16'd1;
        sw_d2 = sw_d1;
        sw_d1 = switchesIn;
    endtask

    task automatic model_reset();
        q_m.delete();
        ovf_m    = 1'b0;
        cyc_m    = '0;
        sw_d1    = '0;
        sw_d2    = '0;
        exp_rd   = '0;
        rd_known = 1'b1;
    endtask

    task automatic step(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input bit rdy);
        memRead      = rd;
        memWrite     = wr;
        memAddr      = a;
        memWriteData = wd;
        ioReady      = rdy;
        @(posedge clk);
        model_edge(rd, wr, a, wd, rdy);
        #1;
        $display("txn t=%0t rd=%0d wr=%0d addr=%h wdata=%h ready=%0d -> rdata=%h valid=%0d data=%h",
                 $time, rd, wr, a, wd, rdy, memReadData, ioValid, ioData);
    endtask

    task automatic check_model(input string tag);
        if (rd_known) check({tag, ".rdata"}, memReadData, exp_rd);
        check({tag, ".valid"}, {15'b0, ioValid}, {15'b0, q_m.size() > 0});
        check({tag, ".data"}, ioData, (q_m.size() > 0) ? q_m[0] : 16'h0000);
    endtask

    task automatic do_reset(input string tag);
        memRead  = 1'b0;
        memWrite = 1'b0;
        ioReady  = 1'b0;
        reset    = 1'b0;
        #1;
        check({tag, ".rst_rdata"}, memReadData, 16'h0000);
        check({tag, ".rst_valid"}, {15'b0, ioValid}, 16'h0000);
        check({tag, ".rst_data"}, ioData, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        $display("txn t=%0t reset released", $time);
    endtask

    initial begin
        logic [15:0] seq [4];
        logic [15:0] a;
        int          kind;
        int          op;
        int          guard;

        for (int i = 0; i < DEPTH; i++) ram_known[i] = 1'b0;
        model_reset();

        //          rd    wr    addr      wdata     rdy   exp_rd    v     data
        tbl[0]  = '{1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'h0405, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 16'h0301, 16'h1111, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 16'hFF01, 16'h2222, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0, 1'b1, 16'hFFF0, 16'h3333, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, 16'h0301, 16'h0000, 1'b0, 16'h1111, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 1'b0, 16'h1111, 1'b0, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h000A, 1'b0, 16'h0000};
        tbl[11] = '{1'b0, 1'b1, 16'hFF00, 16'h00A1, 1'b0, 16'h000A, 1'b1, 16'h00A1};
        tbl[12] = '{1'b0, 1'b1, 16'hFF00, 16'h00A2, 1'b0, 16'h000A, 1'b1, 16'h00A1};
        tbl[13] = '{1'b0, 1'b1, 16'hFF00, 16'h00A3, 1'b0, 16'h000A, 1'b1, 16'h00A1};
        tbl[14] = '{1'b0, 1'b1, 16'hFF00, 16'h00A4, 1'b0, 16'h000A, 1'b1, 16'h00A1};
        tbl[15] = '{1'b0, 1'b1, 16'hFF00, 16'h00A5, 1'b0, 16'h000A, 1'b1, 16'h00A1};
        tbl[16] = '{1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h8024, 1'b1, 16'h00A1};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8024, 1'b1, 16'h00A2};
        tbl[18] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8024, 1'b1, 16'h00A3};
        tbl[19] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8024, 1'b1, 16'h00A4};
        tbl[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8024, 1'b0, 16'h0000};
        tbl[21] = '{1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h8010, 1'b0, 16'h0000};
        tbl[22] = '{1'b0, 1'b1, 16'hFF03, 16'hFFFF, 1'b0, 16'h8010, 1'b0, 16'h0000};
        tbl[23] = '{1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000};
        tbl[24] = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[25] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000};
        tbl[26] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[27] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h0000};
        tbl[28] = '{1'b1, 1'b0, 16'hFF04, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};

        #2;
        do_reset("init");

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ready);
            check($sformatf("vec%0d.rdata", i), memReadData, tbl[i].exp_rd);
            check($sformatf("vec%0d.valid", i), {15'b0, ioValid}, {15'b0, tbl[i].exp_valid});
            check($sformatf("vec%0d.data", i), ioData, tbl[i].exp_data);
        end

        // Full FIFO with simultaneous push and pop
        step(1'b0, 1'b1, 16'hFF00, 16'h00C1, 1'b0);
        step(1'b0, 1'b1, 16'hFF00, 16'h00C2, 1'b0);
        step(1'b0, 1'b1, 16'hFF00, 16'h00C3, 1'b0);
        step(1'b0, 1'b1, 16'hFF00, 16'h00C4, 1'b0);
        step(1'b0, 1'b1, 16'hFF00, 16'h00C0, 1'b1);
        check("fullpp.head", ioData, 16'h00C2);
        step(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0);
        check("fullpp.stat", memReadData, 16'h0024);
        seq = '{16'h00C2, 16'h00C3, 16'h00C4, 16'h00C0};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpp.drain%0d", i), ioData, seq[i]);
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        end
        check("fullpp.empty", {15'b0, ioValid}, 16'h0000);

        // Overflow then clear via STAT write
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'hFF00, 16'h00D0 + 16'(i), 1'b0);
        step(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0);
        check("ovf.stat_set", memReadData, 16'h8024);
        step(1'b0, 1'b1, 16'hFF03, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0);
        check("ovf.stat_clr", memReadData, 16'h0024);
        check("ovf.head", ioData, 16'h00D0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        check_model("ovf.after");

        // Switch synchroniser latency
        step(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0);
        check("sw.before", memReadData, 16'h0000);
        switchesIn = 16'h00F0;
        step(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0);
        check("sw.edge1", memReadData, 16'h0000);
        step(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0);
        check("sw.edge2", memReadData, 16'h0000);
        step(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0);
        check("sw.edge3", memReadData, 16'h00F0);

        // Reset mid-stream with three words queued and CYC at 0x0100
        do_reset("mid");
        step(1'b0, 1'b1, 16'h0020, 16'h7777, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hFF00, 16'h00E0 + 16'(i), 1'b0);
        guard = 0;
        while (cyc_m != 16'h0100 && guard < 1000) begin
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            guard++;
        end
        step(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0);
        check("mid.cyc", memReadData, 16'h0100);
        check("mid.valid", {15'b0, ioValid}, 16'h0001);
        #3;
        do_reset("mid2");
        step(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0);
        check("mid.cyc_after", memReadData, 16'h0000);
        step(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        check("mid.ram_kept", memReadData, 16'h7777);
        check("mid.fifo_empty", {15'b0, ioValid}, 16'h0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 3);
            case (kind)
                0, 1, 2, 3: a = {6'($urandom_range(0, 62)), 10'($urandom_range(0, 7))};
                4:          a = 16'hFF00;
                5:          a = 16'hFF01;
                6:          a = 16'hFF02;
                7, 8:       a = 16'hFF03;
                default:    a = 16'hFF04 + 16'($urandom_range(0, 251));
            endcase
            if ($urandom_range(0, 7) == 0) switchesIn = 16'($urandom);
            step(op == 0 || op == 2, op == 1 || op == 2, a, 16'($urandom),
                 $urandom_range(0, 1) == 1);
            check_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
